rst_seq_ctrl: RTL



---
 rtl/rst_seq_pkg.sv | 28 ++
 rtl/rst_seq_debounce.sv | 56 +++++
 rtl/rst_seq_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM state and reset-cause encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rst_seq_pkg;

  localparam int RstCauseW = 2;

  typedef enum logic [1:0] {
    StReset   = 2'd0,
    StHold    = 2'd1,
    StRelease = 2'd2,
    StRun     = 2'd3
  } rst_seq_state_e;

  typedef enum logic [RstCauseW-1:0] {
    RstCausePor = 2'd0,
    RstCausePll = 2'd1,
    RstCauseBtn = 2'd2,
    RstCauseSw  = 2'd3
  } rst_cause_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rst_seq_debounce.sv
// 2-flop synchronizer for an async level input, with an optional debounce filter.
// Latency: 2 cycles sync; with debounce, DebounceCycles further cycles of stable level.
// Backpressure: none (free-running level path).
// Ports: clk_sys_i/rst_sys_ni clock and async active-low reset, d_i raw async level,
//        q_o synchronized (and optionally debounced) level; all flops reset to 0.
module rst_seq_debounce #(
  parameter int DebounceCycles = 1024,
  parameter bit DebounceEn     = 1'b1
) (
  input  logic clk_sys_i,
  input  logic rst_sys_ni,
  input  logic d_i,
  output logic q_o
);

  logic sync_q1;
  logic sync_q2;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= d_i;
      sync_q2 <= sync_q1;
    end
  end

  if (DebounceEn) begin : g_debounce
    localparam int DbW = $clog2(DebounceCycles) + 1;

    logic [DbW-1:0] cnt_q;
    logic           state_q;

    // cnt_q counts consecutive samples that disagree with the accepted state;
    // any agreeing sample restarts the count, so bounces never accumulate.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
        cnt_q   <= '0;
        state_q <= 1'b0;
      end else if (sync_q2 == state_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DbW'(DebounceCycles - 1)) begin
        cnt_q   <= '0;
        state_q <= sync_q2;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign q_o = state_q;
  end else begin : g_sync_only
    assign q_o = sync_q2;
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: merges PLL lock, button and software sources, then releases
// active-low domain resets in order. Latency: domain k released HoldCycles+k*StepCycles
// after sources clear; source-to-assert 1 cycle after sync/debounce. Backpressure: none.
// Ports: clk_sys_i, rst_sys_ni (async active-low), pll_locked_i, btn_rst_ni (async),
//        sw_rst_req_i (sync pulse); dom_rst_no, seq_done_o, rst_cause_o (all registered).
// Build option: RST_SEQ_BTN_DEBOUNCE_EN enables the button debounce filter.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NumDomains     = 3,
  parameter int HoldCycles     = 16,
  parameter int StepCycles     = 8,
  parameter int DebounceCycles = 1024
) (
  input  logic                  clk_sys_i,
  input  logic                  rst_sys_ni,
  input  logic                  pll_locked_i,
  input  logic                  btn_rst_ni,
  input  logic                  sw_rst_req_i,
  output logic [NumDomains-1:0] dom_rst_no,
  output logic                  seq_done_o,
  output logic [RstCauseW-1:0]  rst_cause_o
);

  localparam int CntW = $clog2(max3(HoldCycles, StepCycles, DebounceCycles)) + 1;
  localparam int IdxW = $clog2(NumDomains) + 1;

`ifdef RST_SEQ_BTN_DEBOUNCE_EN
  localparam bit BtnDebounceEn = 1'b1;
`else
  localparam bit BtnDebounceEn = 1'b0;
`endif

  logic lock_s;
  logic btn_s;

  rst_seq_debounce #(
    .DebounceCycles(DebounceCycles),
    .DebounceEn    (1'b0)
  ) u_lock_sync (
    .clk_sys_i (clk_sys_i),
    .rst_sys_ni(rst_sys_ni),
    .d_i       (pll_locked_i),
    .q_o       (lock_s)
  );

  rst_seq_debounce #(
    .DebounceCycles(DebounceCycles),
    .DebounceEn    (BtnDebounceEn)
  ) u_btn_sync (
    .clk_sys_i (clk_sys_i),
    .rst_sys_ni(rst_sys_ni),
    .d_i       (btn_rst_ni),
    .q_o       (btn_s)
  );

  // Software requests only matter once the sequence has started; in RESET the
  // hardware sources alone decide when HOLD begins.
  logic hw_src;
  logic src_active;
  assign hw_src     = ~lock_s | ~btn_s;
  assign src_active = hw_src | sw_rst_req_i;

  rst_cause_e cause_d;
  always_comb begin
    cause_d = RstCauseSw;
    if (!lock_s)     cause_d = RstCausePll;
    else if (!btn_s) cause_d = RstCauseBtn;
  end

  rst_seq_state_e        state_q;
  logic [CntW-1:0]       cnt_q;
  logic [IdxW-1:0]       idx_q;
  logic [NumDomains-1:0] dom_q;
  logic                  done_q;
  rst_cause_e            cause_q;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state_q <= StReset;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      done_q  <= 1'b0;
      cause_q <= RstCausePor;
    end else if (state_q == StReset) begin
      if (!hw_src) begin
        state_q <= StHold;
        cnt_q   <= CntW'(HoldCycles - 1);
      end
    end else if (src_active) begin
      state_q <= StReset;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      done_q  <= 1'b0;
      cause_q <= cause_d;
    end else begin
      case (state_q)
        StHold: begin
          if (cnt_q == '0) begin
            dom_q[0] <= 1'b1;
            idx_q    <= IdxW'(1);
            if (NumDomains == 1) begin
              state_q <= StRun;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRelease;
              cnt_q   <= CntW'(StepCycles - 1);
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StRelease: begin
          if (cnt_q == '0) begin
            dom_q <= dom_q | (NumDomains'(1) << idx_q);
            if (idx_q == IdxW'(NumDomains - 1)) begin
              state_q <= StRun;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
              cnt_q <= CntW'(StepCycles - 1);
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dom_rst_no  = dom_q;
  assign seq_done_o  = done_q;
  assign rst_cause_o = cause_q;

endmodule
